// File: rtl/lock_pkg.sv
// Shared types and constants for the serial password lock.
// Includes the state encoding, admin code and status decode helpers.
package lock_pkg;

    typedef enum logic [2:0] {
        L_IDLE  = 3'd0,
        L_ENTRY = 3'd1,
        L_OPEN  = 3'd2,
        L_FAIL  = 3'd3,
        L_SET   = 3'd4,
        L_ALARM = 3'd5
    } LockState;

    localparam int PW_LEN = 4;

    // Digit 0 sits in the most significant nibble.
    localparam logic [4*PW_LEN-1:0] ADMIN_CODE = {4'd9, 4'd5, 4'd2, 4'd7};

    typedef struct packed {
        logic       unlocked;
        logic       error;
        logic       alarm;
        logic       set_mode;
        logic [2:0] state;
    } status_t;

    function automatic logic [3:0] admin_digit(input logic [1:0] i);
        logic [3:0] d;
        case (i)
            2'd0:    d = ADMIN_CODE[15:12];
            2'd1:    d = ADMIN_CODE[11:8];
            2'd2:    d = ADMIN_CODE[7:4];
            2'd3:    d = ADMIN_CODE[3:0];
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    function automatic status_t decode_status(input LockState s);
        status_t st;
        st.unlocked = (s == L_OPEN);
        st.error    = (s == L_FAIL);
        st.alarm    = (s == L_ALARM);
        st.set_mode = (s == L_SET);
        st.state    = s;
        return st;
    endfunction

endpackage

// File: rtl/lock_controller_digit_index_counter.sv
// Two-bit digit position counter with clear, increment and last-digit flag.
module digit_index_counter
    import lock_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       inc,
    output logic [1:0] idx,
    output logic       last
);

    logic [1:0] idx_r;

    // Position register; clear wins over increment, wraps 3 -> 0
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx_r <= 2'd0;
        end else if (clr) begin
            idx_r <= 2'd0;
        end else if (inc) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    assign idx  = idx_r;
    assign last = (idx_r == 2'd3);

endmodule

// File: rtl/lock_controller.sv
// Password lock sequencer: digit compare, code change, fail counting and alarm.
// Memory ports are combinational; status outputs are registered from next state.
module lock_controller
    import lock_pkg::*;
#(
    parameter int MAX_FAIL = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       set_req,
    input  logic       lock_req,
    output logic [1:0] rd_addr,
    input  logic [3:0] rd_data,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic [3:0] wr_data,
    output logic       unlocked,
    output logic       error,
    output logic       alarm,
    output logic       set_mode,
    output logic [2:0] state_o
);

    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    LockState          state_r;
    LockState          state_nxt_s;
    logic              mismatch_r;
    logic              mismatch_nxt_s;
    logic [FAIL_W-1:0] fail_cnt_r;
    logic [FAIL_W-1:0] fail_cnt_nxt_s;
    logic [FAIL_W-1:0] fail_inc_s;
    status_t           status_r;
    logic [1:0]        idx_s;
    logic              last_s;
    logic              idx_clr_s;
    logic              idx_inc_s;
    logic [3:0]        ref_s;
    logic              miss_now_s;
    logic              miss_all_s;

    digit_index_counter u_idx (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (idx_clr_s),
        .inc  (idx_inc_s),
        .idx  (idx_s),
        .last (last_s)
    );

    // Memory port drive and selection of the reference digit
    always_comb begin
        rd_addr = 2'd0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 4'd0;
        ref_s   = rd_data;
        case (state_r)
            L_IDLE, L_ENTRY, L_FAIL: begin
                rd_addr = idx_s;
                ref_s   = rd_data;
            end
            L_ALARM: begin
                ref_s = admin_digit(idx_s);
            end
            L_SET: begin
                if (digit_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = idx_s;
                    wr_data = digit;
                end else begin
                    wr_en   = 1'b0;
                end
            end
            default: begin
                ref_s = rd_data;
            end
        endcase
    end

    assign miss_now_s = (digit != ref_s);
    assign miss_all_s = mismatch_r | miss_now_s;
    assign fail_inc_s = fail_cnt_r + {{(FAIL_W-1){1'b0}}, 1'b1};

    // Next state, sticky mismatch, fail count and index control
    always_comb begin
        state_nxt_s    = state_r;
        mismatch_nxt_s = mismatch_r;
        fail_cnt_nxt_s = fail_cnt_r;
        idx_clr_s      = 1'b0;
        idx_inc_s      = 1'b0;
        case (state_r)
            L_IDLE, L_FAIL: begin
                if (digit_valid) begin
                    state_nxt_s    = L_ENTRY;
                    mismatch_nxt_s = miss_now_s;
                    idx_inc_s      = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            L_ENTRY: begin
                if (digit_valid) begin
                    idx_inc_s = 1'b1;
                    if (last_s) begin
                        mismatch_nxt_s = 1'b0;
                        if (!miss_all_s) begin
                            state_nxt_s    = L_OPEN;
                            fail_cnt_nxt_s = '0;
                        end else if (fail_inc_s == FAIL_W'(MAX_FAIL)) begin
                            state_nxt_s    = L_ALARM;
                            fail_cnt_nxt_s = fail_inc_s;
                        end else begin
                            state_nxt_s    = L_FAIL;
                            fail_cnt_nxt_s = fail_inc_s;
                        end
                    end else begin
                        mismatch_nxt_s = miss_all_s;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            L_OPEN: begin
                if (set_req) begin
                    state_nxt_s = L_SET;
                    idx_clr_s   = 1'b1;
                end else if (lock_req) begin
                    state_nxt_s = L_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            L_SET: begin
                if (digit_valid) begin
                    idx_inc_s = 1'b1;
                    if (last_s) begin
                        state_nxt_s = L_IDLE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            L_ALARM: begin
                if (digit_valid) begin
                    idx_inc_s = 1'b1;
                    if (last_s) begin
                        mismatch_nxt_s = 1'b0;
                        if (!miss_all_s) begin
                            state_nxt_s    = L_IDLE;
                            fail_cnt_nxt_s = '0;
                        end else begin
                            state_nxt_s = L_ALARM;
                        end
                    end else begin
                        mismatch_nxt_s = miss_all_s;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s    = L_IDLE;
                mismatch_nxt_s = 1'b0;
                fail_cnt_nxt_s = '0;
                idx_clr_s      = 1'b1;
            end
        endcase
    end

    // State registers with status decoded from the next state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= L_IDLE;
            mismatch_r <= 1'b0;
            fail_cnt_r <= '0;
            status_r   <= '0;
        end else begin
            state_r    <= state_nxt_s;
            mismatch_r <= mismatch_nxt_s;
            fail_cnt_r <= fail_cnt_nxt_s;
            status_r   <= decode_status(state_nxt_s);
        end
    end

    assign unlocked = status_r.unlocked;
    assign error    = status_r.error;
    assign alarm    = status_r.alarm;
    assign set_mode = status_r.set_mode;
    assign state_o  = status_r.state;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with a behavioural 4x4 password memory.
module tb_lock_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] digit;
    logic       digit_valid;
    logic       set_req;
    logic       lock_req;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       unlocked;
    logic       error;
    logic       alarm;
    logic       set_mode;
    logic [2:0] state_o;

    logic [3:0] mem [4];
    logic       mem_init;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] cap_rd;
    logic       cap_we;
    logic [1:0] cap_wa;
    logic [3:0] cap_wd;

    lock_controller #(.MAX_FAIL(3)) dut (
        .CLK(CLK), .RST(RST), .digit(digit), .digit_valid(digit_valid),
        .set_req(set_req), .lock_req(lock_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .unlocked(unlocked),
        .error(error), .alarm(alarm), .set_mode(set_mode), .state_o(state_o)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_init) begin
            mem[0] <= 4'd1; mem[1] <= 4'd2; mem[2] <= 4'd3; mem[3] <= 4'd4;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end
    assign rd_data = mem[rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge CLK);
        digit = d;
        digit_valid = 1'b1;
        #1;
        cap_rd = rd_addr; cap_we = wr_en; cap_wa = wr_addr; cap_wd = wr_data;
        @(posedge CLK);
        #1;
        digit_valid = 1'b0;
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = 0; i < 4; i++) press(code[(15 - 4*i) -: 4]);
    endtask

    task automatic req(input logic s, input logic l);
        @(negedge CLK);
        set_req = s; lock_req = l;
        @(posedge CLK);
        #1;
        set_req = 1'b0; lock_req = 1'b0;
    endtask

    task automatic reset_now(input string tag);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk(tag, {unlocked, error, alarm, set_mode, state_o, wr_en, wr_addr, wr_data, rd_addr}, 32'd0);
        chk({tag, "_fail_cnt"}, 32'(dut.fail_cnt_r), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; digit = 4'd0; digit_valid = 1'b0; set_req = 1'b0; lock_req = 1'b0;
        mem_init = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_outs", {unlocked, error, alarm, set_mode, state_o, wr_en, wr_addr, wr_data}, 32'd0);
        mem_init = 1'b0;
        RST = 1'b1;

        // 1: correct code 1,2,3,4 with read address stepping
        for (int i = 0; i < 4; i++) begin
            press(4'(i + 1));
            chk("t1_rd_addr", 32'(cap_rd), 32'(i));
            if (i < 3) chk("t1_not_yet_open", 32'(unlocked), 32'd0);
        end
        chk("t1_unlocked", 32'(unlocked), 32'd1);
        chk("t1_state", 32'(state_o), 32'd2);
        chk("t1_fail_cnt", 32'(dut.fail_cnt_r), 32'd0);

        // 2: change code to 5,6,7,8
        req(1'b1, 1'b0);
        chk("t2_set_mode", 32'(set_mode), 32'd1);
        for (int i = 0; i < 4; i++) begin
            press(4'(i + 5));
            chk("t2_write", {cap_we, cap_wa, cap_wd}, {25'd0, 1'b1, 2'(i), 4'(i + 5)});
        end
        chk("t2_idle", {set_mode, state_o}, 32'd0);
        enter(16'h5678);
        chk("t2_unlocked_new", 32'(unlocked), 32'd1);
        req(1'b0, 1'b1);
        chk("t2_relock", 32'(state_o), 32'd0);

        // 3: wrong first digit still consumes all four
        press(4'd9); press(4'd6); press(4'd7);
        chk("t3_no_abort", 32'(state_o), 32'd1);
        press(4'd8);
        chk("t3_error", {unlocked, error, alarm}, 32'b010);
        chk("t3_fail_cnt", 32'(dut.fail_cnt_r), 32'd1);
        press(4'd5);
        chk("t3_error_clear", {error, state_o}, {28'd0, 1'b0, 3'd1});
        press(4'd6); press(4'd7); press(4'd8);
        chk("t3_unlock", {unlocked, 3'(dut.fail_cnt_r)}, 32'b1000);
        req(1'b0, 1'b1);

        // 4: three failures raise alarm, only admin code clears
        enter(16'h0000);
        enter(16'h0000);
        chk("t4_fail2", {error, alarm, 3'(dut.fail_cnt_r)}, 32'b10010);
        enter(16'h0000);
        chk("t4_alarm", {error, alarm, state_o}, 32'b01101);
        req(1'b1, 1'b1);
        chk("t4_req_ignored", 32'(state_o), 32'd5);
        enter(16'h5678);
        chk("t4_user_code", 32'(alarm), 32'd1);
        chk("t4_alarm_rd_addr", 32'(cap_rd), 32'd0);
        enter(16'h9527);
        chk("t4_admin", {alarm, state_o, 3'(dut.fail_cnt_r)}, 32'd0);

        // 5: success resets the failure count
        enter(16'h1111);
        enter(16'h2222);
        chk("t5_fail2", 32'(dut.fail_cnt_r), 32'd2);
        enter(16'h5678);
        chk("t5_unlock", {unlocked, 3'(dut.fail_cnt_r)}, 32'b1000);
        req(1'b0, 1'b1);
        chk("t5_locked", 32'(state_o), 32'd0);
        enter(16'h5679);
        chk("t5_single_fail", {error, alarm}, 32'b10);

        // 6: async reset mid-entry and mid-set, then set beats lock
        press(4'd5); press(4'd6);
        reset_now("t6_rst_entry");
        enter(16'h5678);
        chk("t6_unlock1", 32'(unlocked), 32'd1);
        req(1'b1, 1'b0);
        press(4'd1); press(4'd2);
        reset_now("t6_rst_set");
        enter(16'h1278);
        chk("t6_partial_code", 32'(unlocked), 32'd1);
        req(1'b1, 1'b1);
        chk("t6_set_wins", {set_mode, state_o}, 32'b1100);
        press(4'hF);
        chk("t6_digit_gt9", {cap_we, cap_wa, cap_wd}, 32'b1_00_1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
